mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Sequences and arbitrates the single byte-wide RAM/IO port between the instruction-fetch stage (IF) and the data-memory stage (MEM).
- Converts word, half and byte requests into back-to-back byte transactions and reassembles read data little-endian.
- Drives a busy code and a one-cycle done pulse, which the MEM stage's combinational request logic consumes directly.
- MEM has priority and may preempt an in-flight instruction fetch.

Parameters:
IO_SEL_HI, 17, upper bit of the IO-region address field.
IO_SEL_LO, 16, lower bit of the IO-region address field; the IO region is addr[IO_SEL_HI:IO_SEL_LO]==2'b11.

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  global ready; when low, all state, counters and outputs hold
if_req_in  input  1  IF fetch request, level, held until if_done_out
if_addr_in  input  32  IF fetch address
if_done_out  output  1  one-cycle pulse: inst_out valid
inst_out  output  32  fetched instruction
read_req_in  input  1  MEM load request, level
write_req_in  input  1  MEM store request, level
mem_addr_in  input  32  MEM byte address
mem_val_in  input  32  MEM store data, byte 0 = bits 7:0
store_len_in  input  3  read: byte count (1, 2 or 4); write: byte count minus 1 (0, 1 or 3)
mem_done_out  output  1  one-cycle pulse: MEM access complete
mem_val_read_out  output  32  load data, unused upper bytes zero
memctrl_busy_out  output  2  00 idle, 01 serving IF, 10 serving MEM
ram_din_in  input  8  RAM/IO read byte, valid one cycle after its address
ram_dout_out  output  8  RAM/IO write byte
ram_a_out  output  32  RAM/IO byte address
ram_wr_out  output  1  1 = write, 0 = read
io_buffer_full_in  input  1  IO write buffer full

Behaviour:
- Reset (rst_in low, asynchronous): state IDLE, counter 0.
  - All outputs are 0 immediately, including ram_wr_out and both done pulses.
  - Any operation in progress is discarded; nothing is completed after reset releases.
- States: IDLE, IF_RD, MEM_RD, MEM_WR.
  - memctrl_busy_out = 00 in IDLE, 01 in IF_RD, 10 in MEM_RD or MEM_WR.
- Request acceptance is sampled at the clock edge, in IDLE only, and only when neither done output is high that cycle. The done-cycle exclusion prevents re-accepting a request that MEM or IF is just dropping.
- Priority: write_req_in over read_req_in over if_req_in.
- On acceptance, latch address, data and length, clear counter cnt, and enter the target state.
- Length N:
  - Reads: N = store_len_in.
  - Writes: N = store_len_in + 1.
  - IF: N = 4.
- Read states (IF_RD, MEM_RD):
  - In the cycle with cnt = k < N: ram_a_out = addr + k, ram_wr_out = 0.
  - At each edge with 1 ≤ cnt ≤ N: capture ram_din_in into byte cnt−1.
  - cnt increments every edge.
  - At the edge where cnt = N: capture the last byte, assert the done output with assembled data for exactly the next cycle, and return to IDLE.
  - Total latency is N+1 edges from acceptance to the done cycle.
  - Address addition wraps modulo 2^32.
- Write state (MEM_WR):
  - In the cycle with cnt = k < N: ram_a_out = addr + k, ram_dout_out = data byte k, ram_wr_out = 1.
  - At the edge with cnt = N−1: assert mem_done_out for the next cycle and return to IDLE.
- IO stall: in MEM_WR, if the latched addr is in the IO region and io_buffer_full_in = 1, then ram_wr_out = 0 and cnt holds. Resume when io_buffer_full_in drops.
- Preemption:
  - In IF_RD, read_req_in or write_req_in high at an edge aborts the fetch, with no if_done_out, and enters MEM_RD or MEM_WR with cnt = 0.
  - The fetch restarts from byte 0 after the MEM access completes, if if_req_in is still high.
- Fetch cancel: if_req_in low at an edge in IF_RD returns to IDLE with no done pulse.
- MEM requests are never aborted.
- Outside active read or write cycles: ram_a_out = 0, ram_wr_out = 0, ram_dout_out = 0.
- inst_out and mem_val_read_out hold their last values. Consumers qualify them with the done pulses only.

Test Plan:
- LW: RAM holds 0x78,0x56,0x34,0x12 at 0x100; read_req, store_len = 4 → ram_a_out 0x100..0x103 on 4 consecutive cycles; mem_done_out for one cycle, 5 edges after acceptance; mem_val_read_out = 0x12345678; busy = 10 throughout.
- LB/LH: store_len 1 at 0x101 → value 0x00000056. store_len 2 at 0x102 → value 0x00001234.
- SH: mem_val_in = 0xAABBCCDD, store_len = 1, addr 0x200 → wr = 1 with 0x200/0xDD, then 0x201/0xCC; done on the next cycle; 0x202 is never written.
- Preemption: IF fetching 0x0 at cnt = 2, read_req at 0x100 → fetch aborted with no if_done; MEM done with 0x12345678; IF then re-reads 0x0..0x3 and if_done fires with the correct word.
- IO stall: SB to 0x30000 with io_buffer_full = 1 for 3 cycles → ram_wr_out stays 0 for 3 cycles, then one write of the byte, then done.
- Reset mid-write: rst_in low during byte 1 of an SW → ram_wr_out = 0 immediately, no done; after release, state is IDLE and busy = 00.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the single byte-wide RAM/IO port between instruction
// fetch (IF) and the data-memory stage (MEM).
//   - Word, half and byte requests are split into back-to-back byte accesses.
//   - Read data is reassembled little-endian.
//   - MEM has priority over IF and may preempt an in-flight fetch.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global stall)
//   if_req_in / if_addr_in / if_done_out / inst_out         : fetch side
//   read_req_in / write_req_in / mem_addr_in / mem_val_in /
//   store_len_in / mem_done_out / mem_val_read_out          : MEM side
//   memctrl_busy_out                                        : 00 idle, 01 IF, 10 MEM
//   ram_din_in / ram_dout_out / ram_a_out / ram_wr_out      : byte RAM/IO port
//   io_buffer_full_in                                       : stalls IO-region writes
module mem_ctrl #(
  parameter int IO_SEL_HI = 17,
  parameter int IO_SEL_LO = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        if_req_in,
  input  logic [31:0] if_addr_in,
  output logic        if_done_out,
  output logic [31:0] inst_out,
  input  logic        read_req_in,
  input  logic        write_req_in,
  input  logic [31:0] mem_addr_in,
  input  logic [31:0] mem_val_in,
  input  logic [2:0]  store_len_in,
  output logic        mem_done_out,
  output logic [31:0] mem_val_read_out,
  output logic [1:0]  memctrl_busy_out,
  input  logic [7:0]  ram_din_in,
  output logic [7:0]  ram_dout_out,
  output logic [31:0] ram_a_out,
  output logic        ram_wr_out,
  input  logic        io_buffer_full_in
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IF_RD  = 2'd1,
    S_MEM_RD = 2'd2,
    S_MEM_WR = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [3:0]  r_len;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_buf;
  logic [31:0] r_inst;
  logic [31:0] r_mem_val;
  logic        r_if_done;
  logic        r_mem_done;

  logic        w_idle_ok;
  logic        w_mem_req;
  logic        w_take_mem;
  logic        w_take_if;
  logic        w_stall;
  logic        w_rd_active;
  logic        w_wr_active;
  logic [3:0]  w_mem_len;
  logic [31:0] w_merged;

  function automatic logic [31:0] put_byte(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [7:0]  b);
    logic [31:0] res;
    res = word;
    case (idx)
      2'd0:    res[7:0]   = b;
      2'd1:    res[15:8]  = b;
      2'd2:    res[23:16] = b;
      2'd3:    res[31:24] = b;
      default: res        = word;
    endcase
    return res;
  endfunction

  function automatic logic [7:0] get_byte(input logic [31:0] word,
                                          input logic [1:0]  idx);
    logic [7:0] res;
    case (idx)
      2'd0:    res = word[7:0];
      2'd1:    res = word[15:8];
      2'd2:    res = word[23:16];
      2'd3:    res = word[31:24];
      default: res = 8'd0;
    endcase
    return res;
  endfunction

  // Acceptance / preemption decisions and byte-port decode
  always_comb begin
    // A done pulse blocks acceptance so a request being dropped is not re-taken
    w_idle_ok   = (r_state == S_IDLE) && !r_if_done && !r_mem_done;
    w_mem_req   = write_req_in || read_req_in;
    w_take_mem  = w_mem_req && (w_idle_ok || (r_state == S_IF_RD));
    w_take_if   = if_req_in && w_idle_ok && !w_mem_req;
    w_mem_len   = write_req_in ? ({1'b0, store_len_in} + 4'd1) : {1'b0, store_len_in};
    w_stall     = (r_state == S_MEM_WR) && io_buffer_full_in &&
                  (r_addr[IO_SEL_HI:IO_SEL_LO] == 2'b11);
    w_rd_active = ((r_state == S_IF_RD) || (r_state == S_MEM_RD)) && (r_cnt < r_len);
    w_wr_active = (r_state == S_MEM_WR) && (r_cnt < r_len);
    // The byte arriving now belongs to the address issued one cycle earlier
    if (r_cnt != 4'd0) begin
      w_merged = put_byte(r_buf, r_cnt[1:0] - 2'd1, ram_din_in);
    end else begin
      w_merged = r_buf;
    end
    if (w_rd_active || w_wr_active) begin
      ram_a_out = r_addr + {28'd0, r_cnt};
    end else begin
      ram_a_out = 32'd0;
    end
    if (w_wr_active) begin
      ram_dout_out = get_byte(r_wdata, r_cnt[1:0]);
    end else begin
      ram_dout_out = 8'd0;
    end
    ram_wr_out = w_wr_active && !w_stall;
    case (r_state)
      S_IDLE:   memctrl_busy_out = 2'b00;
      S_IF_RD:  memctrl_busy_out = 2'b01;
      S_MEM_RD: memctrl_busy_out = 2'b10;
      S_MEM_WR: memctrl_busy_out = 2'b10;
      default:  memctrl_busy_out = 2'b00;
    endcase
  end

  assign if_done_out      = r_if_done;
  assign mem_done_out     = r_mem_done;
  assign inst_out         = r_inst;
  assign mem_val_read_out = r_mem_val;

  // Sequencer: acceptance, preemption, byte stepping, data capture, done pulses
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_len      <= 4'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_buf      <= 32'd0;
      r_inst     <= 32'd0;
      r_mem_val  <= 32'd0;
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
    end else if (rdy_in) begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      if (w_take_mem) begin
        // Also the preemption path: a fetch in progress is simply dropped
        r_state <= write_req_in ? S_MEM_WR : S_MEM_RD;
        r_addr  <= mem_addr_in;
        r_wdata <= mem_val_in;
        r_len   <= w_mem_len;
        r_cnt   <= 4'd0;
        r_buf   <= 32'd0;
      end else if (w_take_if) begin
        r_state <= S_IF_RD;
        r_addr  <= if_addr_in;
        r_len   <= 4'd4;
        r_cnt   <= 4'd0;
        r_buf   <= 32'd0;
      end else begin
        case (r_state)
          S_IF_RD, S_MEM_RD: begin
            if ((r_state == S_IF_RD) && !if_req_in) begin
              r_state <= S_IDLE;
              r_cnt   <= 4'd0;
            end else begin
              r_buf <= w_merged;
              if (r_cnt == r_len) begin
                r_state <= S_IDLE;
                r_cnt   <= 4'd0;
                if (r_state == S_IF_RD) begin
                  r_inst    <= w_merged;
                  r_if_done <= 1'b1;
                end else begin
                  r_mem_val  <= w_merged;
                  r_mem_done <= 1'b1;
                end
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end
          end
          S_MEM_WR: begin
            if (w_stall) begin
              r_cnt <= r_cnt;
            end else if (r_cnt == (r_len - 4'd1)) begin
              r_state    <= S_IDLE;
              r_cnt      <= 4'd0;
              r_mem_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
